apb_irq_ctrl: RTL
=================

// Module: apb_irq_ctrl
// PURPOSE
// - Parametrised APB interrupt controller, successor to the fixed 2-source controller at 0x2000_0000.
// - Collects NUM_SRC interrupt lines, each with its own edge/level mode, enable and W1C pending bit.
// - Adds a non-maskable input, a priority CLAIM register and a registered irq output to the CPU.
// - Sits on the CPU APB bus beside the timer; its irq output drives the core interrupt pin.
// PARAMETERS
// - ADDR_WIDTH  32            APB address width.
// - DATA_WIDTH  32            APB data width; fixed at 32.
// - NUM_SRC     8             maskable sources, 1..31; src[0] is highest priority.
// - BASE_ADDR   32'h2000_0000 register window base; window size is 0x20.
// PORTS
// - pclk        in   1           clock.
// - presetn     in   1           synchronous active-low reset.
// - paddr       in   ADDR_WIDTH  APB address.
// - pdata       in   DATA_WIDTH  APB write data.
// - prdata      out  DATA_WIDTH  APB read data, registered.
// - psel        in   1           APB select, decoded externally.
// - penable     in   1           APB access phase.
// - pwrite      in   1           1 = write.
// - pstb        in   4           write byte strobes.
// - pready      out  1           transfer complete.
// - perr        out  1           slave error, valid with pready.
// - src         in   NUM_SRC     interrupt requests, synchronous to pclk.
// - nmi         in   1           non-maskable request, level.
// - cpu_interrupt out 1          interrupt to core, registered.
// BEHAVIOUR
// - Reset (presetn=0 at posedge): PENDING, ENABLE, MODE, src_d, prdata, pready, perr, cpu_interrupt all 0.
// - Register map, byte offsets from BASE_ADDR, decoded on paddr[4:2]; paddr[1:0] ignored:
//   0x00 PENDING  R / W1C; 0x04 ENABLE RW; 0x08 MODE RW, 1 = edge, 0 = level;
//   0x0C CLAIM    RO {valid[31], 26'b0, id[4:0]}; 0x10 STATUS RO, PENDING&ENABLE.
//   Offsets 0x14..0x1C, and any paddr outside the window, complete with perr=1 and prdata=0.
// - Bits at index >= NUM_SRC read 0; writes to them are ignored.
// - Handshake: access is accepted when psel & penable & !pready.
//   - pready=1 for exactly one cycle after acceptance (one wait state), then 0.
//   - Write takes effect at the accepting edge, per byte, only where pstb[b]=1.
//   - prdata and perr are loaded at the same edge.
//   - Writes to CLAIM/STATUS: no effect, perr=1.
// - Edge source (MODE[i]=1): src_d[i] <= src[i] every cycle. PENDING[i] is set at an edge where src[i] & ~src_d[i].
//   - A W1C write clears the bit.
//   - Set and clear in the same cycle: set wins.
// - Level source (MODE[i]=0): PENDING[i] <= src[i] every cycle; W1C has no effect.
// - Changing MODE doesn't clear PENDING; a level bit then tracks src from the next cycle.
// - After reset src_d=0, so an edge source already high at reset release pends one cycle later.
// - CLAIM: lowest index i with PENDING[i]&ENABLE[i]; valid=0, id=0 if none.
//   - Combinational from current state, sampled into prdata on read.
//   - Reading has no side effect.
// - cpu_interrupt <= |(PENDING & ENABLE) | nmi. nmi ignores ENABLE and is not stored.
// - Latency: edge on src before posedge k -> PENDING at k -> cpu_interrupt at k+1.
// - A W1C of the last active bit at edge k drops cpu_interrupt at k+1.
// - Reset mid-transfer: pready=0 next cycle; the transfer is lost; the master must restart it.
// STRUCTURE
// - Package irqctrl_pkg: register offset localparams (OFS_PENDING..OFS_STATUS), CLAIM_VALID_BIT=31, claim_t struct.
// - Sub-module irq_prio_enc #(N): N-bit vector in -> {valid, id[4:0]} out, lowest index wins, purely combinational.
// TESTING
// - Reset: hold presetn=0 3 cycles with src=all 1 -> all regs 0, cpu_interrupt=0, pready=0.
// - Edge pend and W1C:
//   - MODE=0xFF, ENABLE=0x04; pulse src[2] 1 cycle -> PENDING=0x04, cpu_interrupt=1 two cycles after rise.
//   - Write PENDING=0x04 -> PENDING=0, cpu_interrupt=0 next cycle.
// - Level mode: MODE=0, ENABLE=0x01; hold src[0]=1 -> STATUS=0x01; write PENDING=0x01 -> still 0x01; drop src -> 0.
// - Priority: edge-pend src[5] and src[3], ENABLE=0x28 -> CLAIM=0x8000_0003; clear bit 3 -> CLAIM=0x8000_0005.
// - Collision: W1C of bit 1 at the same edge as a new src[1] rise -> PENDING[1]=1.
// - Bus/NMI:
//   - Read offset 0x14 -> perr=1, prdata=0, pready one cycle.
//   - ENABLE write with pstb=4'b0001, data 0xFFFF_FFFF -> ENABLE=0xFF when NUM_SRC=8.
//   - nmi=1 with ENABLE=0 -> cpu_interrupt=1 next cycle.

Source files
------------

// File: rtl/irqctrl_pkg.sv
// Shared definitions for the APB interrupt controller: register offsets
// within the 0x20-byte window and the layout of the CLAIM word.
package irqctrl_pkg;

    localparam logic [4:0] OFS_PENDING = 5'h00;
    localparam logic [4:0] OFS_ENABLE  = 5'h04;
    localparam logic [4:0] OFS_MODE    = 5'h08;
    localparam logic [4:0] OFS_CLAIM   = 5'h0C;
    localparam logic [4:0] OFS_STATUS  = 5'h10;

    localparam int CLAIM_VALID_BIT = 31;

    // CLAIM register image: valid flag on top, source id in the low five bits
    typedef struct packed {
        logic                         valid;
        logic [CLAIM_VALID_BIT-6:0]   rsvd;
        logic [4:0]                   id;
    } claim_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of an N-bit request
// vector as a CLAIM word. Purely combinational.
module irq_prio_enc
    import irqctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output claim_t       claim
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        claim = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                claim.valid = 1'b1;
                claim.id    = 5'(i);
            end
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: NUM_SRC maskable sources with per-source
// edge/level mode, enable and W1C pending, plus a non-maskable input.
// One wait state per access; read data and error are registered.
module apb_irq_ctrl
    import irqctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    input  logic [NUM_SRC-1:0]    src,
    input  logic                  nmi,
    output logic                  cpu_interrupt
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] wsel;
    logic [NUM_SRC-1:0] wbits;
    logic [NUM_SRC-1:0] w1c;
    logic [31:0]        byte_mask;
    logic [31:0]        rd_val;
    logic               rd_err;
    logic               acc_err;
    logic               access;
    logic               in_window;
    logic [2:0]         reg_idx;
    logic               wr_pend;
    logic               wr_en;
    logic               wr_mode;
    claim_t             claim;
    logic               unused_bits;

    assign access    = psel & penable & ~pready;
    assign in_window = (paddr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign reg_idx   = paddr[4:2];

    assign wr_pend = access & pwrite & in_window & (reg_idx == OFS_PENDING[4:2]);
    assign wr_en   = access & pwrite & in_window & (reg_idx == OFS_ENABLE[4:2]);
    assign wr_mode = access & pwrite & in_window & (reg_idx == OFS_MODE[4:2]);

    // Expand byte strobes to a bit mask over the implemented sources
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{pstb[b]}};
        end
    end

    assign wsel   = byte_mask[NUM_SRC-1:0];
    assign wbits  = pdata[NUM_SRC-1:0] & wsel;
    assign w1c    = wr_pend ? wbits : '0;
    assign active = pending & enable;

    // Address bits [1:0] and data/strobe lanes above NUM_SRC carry no state
    assign unused_bits = ^{paddr[1:0], pdata, byte_mask};

    irq_prio_enc #(.N(NUM_SRC)) u_prio (
        .req   (active),
        .claim (claim)
    );

    // Read mux and access error, evaluated against the current register state
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (!in_window) begin
            rd_err = 1'b1;
        end else begin
            case (reg_idx)
                OFS_PENDING[4:2]: rd_val = 32'(pending);
                OFS_ENABLE[4:2]:  rd_val = 32'(enable);
                OFS_MODE[4:2]:    rd_val = 32'(mode);
                OFS_CLAIM[4:2]:   rd_val = claim;
                OFS_STATUS[4:2]:  rd_val = 32'(active);
                default:          rd_err = 1'b1;
            endcase
        end
        acc_err = rd_err | (pwrite & ((reg_idx == OFS_CLAIM[4:2]) |
                                      (reg_idx == OFS_STATUS[4:2])));
    end

    // Next pending: edge sources latch rises (a rise beats a same-cycle W1C),
    // level sources simply follow the request line
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode[i]) begin
                pend_nxt[i] = (src[i] & ~src_d[i]) | (pending[i] & ~w1c[i]);
            end else begin
                pend_nxt[i] = src[i];
            end
        end
    end

    // Register state, bus response and the registered CPU interrupt
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pending       <= '0;
            enable        <= '0;
            mode          <= '0;
            src_d         <= '0;
            prdata        <= '0;
            pready        <= 1'b0;
            perr          <= 1'b0;
            cpu_interrupt <= 1'b0;
        end else begin
            pending       <= pend_nxt;
            src_d         <= src;
            cpu_interrupt <= (|active) | nmi;
            pready        <= access;
            perr          <= access & acc_err;
            if (wr_en) begin
                enable <= (enable & ~wsel) | wbits;
            end
            if (wr_mode) begin
                mode <= (mode & ~wsel) | wbits;
            end
            if (access) begin
                prdata <= pwrite ? '0 : DATA_WIDTH'(rd_val);
            end
        end
    end

endmodule
